updn_counter_n: RTL and testbench

UPDN_COUNTER_N -- requirements
Module: updn_counter_n

---
 rtl/updn_counter_pkg.sv | 17 +
 rtl/updn_tc_detect.sv | 21 ++
 rtl/updn_counter_n.sv | 96 +++++++++
 tb/tb_updn_counter_n.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/updn_counter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | updn_counter_pkg : shared mode constants and one-shot state type  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package updn_counter_pkg;

  localparam int MODE_WRAP    = 0;
  localparam int MODE_ONESHOT = 1;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/updn_tc_detect.sv
`default_nettype none
// +------------------------------------------------------------------+
// | updn_tc_detect : max/min flag for the current count direction     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module updn_tc_detect #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             down_up_i,
  output logic             m_m_o
);

  localparam logic [WIDTH-1:0] C_MAX = MAX[WIDTH-1:0];

  // Terminal is MAX going up, zero going down; direction applies in the same cycle.
  assign m_m_o = down_up_i ? (q_i == '0) : (q_i == C_MAX);

endmodule
`default_nettype wire

// File: rtl/updn_counter_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | updn_counter_n : cascadable modulo-(MAX+1) up/down counter with   |
// | clamped parallel load and optional one-shot stop. Rev 1.0         |
// +------------------------------------------------------------------+
module updn_counter_n
  import updn_counter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1,
  parameter int MODE  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             down_up,
  input  logic             g,
  input  logic             ci_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             m_m,
  output logic             rco_n,
  output logic             done
);

  localparam logic [WIDTH-1:0] C_MAX = MAX[WIDTH-1:0];
  localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] load_val;
  logic             count_en;

  assign count_en = ~g & ~ci_n;

  updn_tc_detect #(
    .WIDTH (WIDTH),
    .MAX   (MAX)
  ) u_tc (
    .q_i       (cnt_q),
    .down_up_i (down_up),
    .m_m_o     (m_m)
  );

  // Clamp is only needed when the modulus leaves unused codes above MAX.
  generate
    if (MAX < 2**WIDTH-1) begin : g_clamp
      assign load_val = (d > C_MAX) ? C_MAX : d;
    end else begin : g_noclamp
      assign load_val = d;
    end
  endgenerate

  always_comb begin
    cnt_d   = cnt_q;
    state_d = state_q;
    if (!ld) begin
      cnt_d   = load_val;
      state_d = ST_RUN;
    end else if (count_en && (state_q == ST_RUN)) begin
      if (m_m) begin
        if (MODE == MODE_ONESHOT) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = down_up ? C_MAX : '0;
        end
      end else begin
        cnt_d = down_up ? (cnt_q - C_ONE) : (cnt_q + C_ONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  generate
    if (MODE == MODE_ONESHOT) begin : g_oneshot
      assign done = (state_q == ST_DONE);
    end else begin : g_wrap
      assign done = 1'b0;
    end
  endgenerate

  assign q     = cnt_q;
  // Combinational carry so a downstream stage sees it before the same edge.
  assign rco_n = ~(m_m & count_en & ~done);

endmodule
`default_nettype wire

// File: tb/tb_updn_counter_n.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_updn_counter_n : directed checks for wrap, one-shot, cascade   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_updn_counter_n;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // u_a: WIDTH 4, MAX 9, wrap
  logic       a_dn, a_g, a_ld;
  logic [3:0] a_d, a_q;
  logic       a_mm, a_rco, a_done;
  // u_b: WIDTH 4, MAX 5, one-shot
  logic       b_dn, b_g, b_ld;
  logic [3:0] b_d, b_q;
  logic       b_mm, b_rco, b_done;
  // cascade pair, default MAX 15, wrap
  logic       c_g;
  logic [3:0] lo_q, hi_q;
  logic       lo_mm, lo_rco, lo_done, hi_mm, hi_rco, hi_done;

  int errors = 0;
  int checks = 0;

  updn_counter_n #(.WIDTH(4), .MAX(9), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .down_up(a_dn), .g(a_g), .ci_n(1'b0), .ld(a_ld),
    .d(a_d), .q(a_q), .m_m(a_mm), .rco_n(a_rco), .done(a_done));

  updn_counter_n #(.WIDTH(4), .MAX(5), .MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .down_up(b_dn), .g(b_g), .ci_n(1'b0), .ld(b_ld),
    .d(b_d), .q(b_q), .m_m(b_mm), .rco_n(b_rco), .done(b_done));

  updn_counter_n #(.WIDTH(4)) u_lo (
    .clk(clk), .rst_n(rst_n), .down_up(1'b0), .g(c_g), .ci_n(1'b0), .ld(1'b1),
    .d(4'd0), .q(lo_q), .m_m(lo_mm), .rco_n(lo_rco), .done(lo_done));

  updn_counter_n #(.WIDTH(4)) u_hi (
    .clk(clk), .rst_n(rst_n), .down_up(1'b0), .g(c_g), .ci_n(lo_rco), .ld(1'b1),
    .d(4'd0), .q(hi_q), .m_m(hi_mm), .rco_n(hi_rco), .done(hi_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_dn = 1'b0; a_g = 1'b1; a_ld = 1'b1; a_d = 4'd0;
    b_dn = 1'b0; b_g = 1'b1; b_ld = 1'b1; b_d = 4'd0;
    c_g  = 1'b1;
    #12;
    // Reset state and combinational flags
    check("rst_q", a_q, 0);
    check("rst_done", b_done, 0);
    check("rst_mm_up", a_mm, 0);
    check("rst_rco", a_rco, 1);
    a_dn = 1'b1; #1;
    check("rst_mm_dn", a_mm, 1);
    a_dn = 1'b0;
    rst_n = 1'b1;

    // Up wrap at MAX 9
    a_g = 1'b0;
    repeat (9) tick();
    check("up_q9", a_q, 9);
    check("up_mm9", a_mm, 1);
    check("up_rco9", a_rco, 0);
    check("wrap_done0", a_done, 0);
    tick();
    check("up_wrap", a_q, 0);
    check("up_mm0", a_mm, 0);

    // Down wrap: load 2 then 2,1,0,9
    a_g = 1'b1; a_ld = 1'b0; a_d = 4'd2; a_dn = 1'b1;
    tick();
    a_ld = 1'b1;
    check("dn_load", a_q, 2);
    check("dn_mm2", a_mm, 0);
    a_g = 1'b0;
    tick(); check("dn_q1", a_q, 1); check("dn_mm1", a_mm, 0);
    tick(); check("dn_q0", a_q, 0); check("dn_mm0", a_mm, 1);
    check("dn_rco0", a_rco, 0);
    tick(); check("dn_wrap", a_q, 9); check("dn_mm9", a_mm, 0);

    // Load clamp overrides count, then load with g high
    a_ld = 1'b0; a_d = 4'd12; a_g = 1'b0; a_dn = 1'b0;
    tick();
    check("ld_clamp", a_q, 9);
    a_ld = 1'b1; a_g = 1'b1; #1;
    check("mm_dir_up", a_mm, 1);
    a_dn = 1'b1; #1;
    check("mm_dir_dn", a_mm, 0);
    a_ld = 1'b0; a_d = 4'd3;
    tick();
    check("ld_g1", a_q, 3);
    a_ld = 1'b1;

    // One-shot: up to 5, then stop with done
    b_g = 1'b0; b_dn = 1'b0;
    repeat (5) tick();
    check("os_q5", b_q, 5);
    check("os_done_pre", b_done, 0);
    check("os_rco_pre", b_rco, 0);
    tick();
    check("os_hold", b_q, 5);
    check("os_done", b_done, 1);
    check("os_rco_done", b_rco, 1);
    check("os_mm_done", b_mm, 1);
    b_dn = 1'b1;
    tick();
    check("os_frozen_dn", b_q, 5);
    check("os_mm_dn", b_mm, 0);
    b_ld = 1'b0; b_d = 4'd0;
    tick();
    b_ld = 1'b1;
    check("os_ld_q", b_q, 0);
    check("os_ld_done", b_done, 0);
    b_g = 1'b1; b_dn = 1'b0;

    // Cascade: 300 edges -> 44
    c_g = 1'b0;
    repeat (300) tick();
    c_g = 1'b1;
    check("cascade", {hi_q, lo_q}, 44);

    // Async reset between edges
    a_g = 1'b1; a_ld = 1'b0; a_d = 4'd7; a_dn = 1'b0;
    b_ld = 1'b0; b_d = 4'd5;
    tick();
    a_ld = 1'b1; b_ld = 1'b1;
    check("ar_pre_q", a_q, 7);
    b_g = 1'b0;
    tick();
    check("ar_pre_done", b_done, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_q", a_q, 0);
    check("ar_bq", b_q, 0);
    check("ar_done", b_done, 0);
    #1 rst_n = 1'b1;
    a_g = 1'b0;
    tick();
    check("ar_resume_a", a_q, 1);
    check("ar_resume_b", b_q, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
